// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised multi-port register file with bypass, pending scoreboard and soft clear
// Ports:
//   clk, reset                       rising-edge clock, asynchronous active-high reset
//   rd_addr/rd_data/rd_pending       NREAD combinational read ports (sliced per port)
//   wr_en/wr_addr/wr_data            NWRITE write ports, highest index wins on collision
//   rsv_en/rsv_addr                  mark a destination register pending
//   clr_req/clr_busy/clr_done        sequenced soft clear of all registers and pending bits
module regfile_multiport #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*XLEN-1:0]   rd_data,
    output logic [NREAD-1:0]        rd_pending,
    input  logic [NWRITE-1:0]       wr_en,
    input  logic [NWRITE*AW-1:0]    wr_addr,
    input  logic [NWRITE*XLEN-1:0]  wr_data,
    input  logic                    rsv_en,
    input  logic [AW-1:0]           rsv_addr,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic                    clr_done
);
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;
    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    a;
    assign clr_busy = state_q != IDLE;
    assign clr_done = state_q == DONE;
    always_comb begin
        regs_d  = regs_q;
        pend_d  = pend_q;
        state_d = state_q;
        idx_d   = idx_q;
        if (!clr_busy) begin
            // ascending order lets the highest-index port win a same-address collision
            for (int j = 0; j < NWRITE; j++)
                if (wr_en[j] && !(ZERO_REG != 0 && wr_addr[j*AW +: AW] == '0)) begin
                    regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
                    pend_d[wr_addr[j*AW +: AW]] = 1'b0;
                end
            // applied after writes so a same-cycle reservation keeps the register pending
            if (rsv_en && !(ZERO_REG != 0 && rsv_addr == '0))
                pend_d[rsv_addr] = 1'b1;
        end
        if (state_q == IDLE) begin
            if (clr_req) begin
                state_d = CLEAR;
                idx_d   = '0;
            end
        end else if (state_q == CLEAR) begin
            regs_d[idx_q] = '0;
            pend_d[idx_q] = 1'b0;
            idx_d         = idx_q + 1'b1;
            if (idx_q == AW'(NREGS - 1)) begin
                state_d = DONE;
                idx_d   = '0;
            end
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q  <= '{default: '0};
            pend_q  <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            regs_q  <= regs_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end
    always_comb begin
        rd_data    = '0;
        rd_pending = '0;
        a          = '0;
        for (int i = 0; i < NREAD; i++) begin
            a = rd_addr[i*AW +: AW];
            rd_data[i*XLEN +: XLEN] = regs_q[a];
            // forwarding is suppressed during clear and reset so reads show the stored (cleared) state
            if (BYPASS != 0 && !clr_busy && !reset)
                for (int j = 0; j < NWRITE; j++)
                    if (wr_en[j] && wr_addr[j*AW +: AW] == a)
                        rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
            if (ZERO_REG != 0 && a == '0)
                rd_data[i*XLEN +: XLEN] = '0;
            rd_pending[i] = pend_q[a];
        end
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed bench for regfile_multiport in default, no-bypass and wide configurations
module tb_regfile_multiport;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [9:0]  rd_addr;
    logic [63:0] rd_data, b_rd_data;
    logic [1:0]  rd_pending, b_rd_pending;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        clr_req, clr_busy, clr_done, b_clr_busy, b_clr_done;

    logic [11:0]  c_rd_addr;
    logic [191:0] c_rd_data;
    logic [2:0]   c_rd_pending;
    logic [0:0]   c_wr_en;
    logic [3:0]   c_wr_addr;
    logic [63:0]  c_wr_data;
    logic         c_rsv_en;
    logic [3:0]   c_rsv_addr;
    logic         c_clr_req, c_clr_busy, c_clr_done;

    int errors = 0;
    int checks = 0;
    int busy_n, done_n;

    regfile_multiport dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    regfile_multiport #(.BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_pending(b_rd_pending),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(b_clr_busy), .clr_done(b_clr_done)
    );

    regfile_multiport #(.XLEN(64), .NREGS(16), .NREAD(3), .NWRITE(1)) dut_c (
        .clk(clk), .reset(reset), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_pending(c_rd_pending),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .rsv_en(c_rsv_en), .rsv_addr(c_rsv_addr),
        .clr_req(c_clr_req), .clr_busy(c_clr_busy), .clr_done(c_clr_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_clear(input bit use_c, output int b, output int d);
        b = 0;
        d = 0;
        for (int k = 0; k < 100; k++) begin
            if (use_c ? c_clr_busy : clr_busy) b++;
            if (use_c ? c_clr_done : clr_done) d++;
            if (!(use_c ? c_clr_busy : clr_busy)) break;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
        c_rd_addr = '0; c_wr_en = '0; c_wr_addr = '0; c_wr_data = '0;
        c_rsv_en = 1'b0; c_rsv_addr = '0; c_clr_req = 1'b0;
        #3;
        check("reset_rd_data", rd_data, 64'h0);
        check("reset_pending", {62'h0, rd_pending}, 64'h0);
        check("reset_busy", {63'h0, clr_busy}, 64'h0);
        check("reset_done", {63'h0, clr_done}, 64'h0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        tick();
        wr_en = 2'b00; rd_addr = {5'd5, 5'd0}; #1;
        check("rd1_addr5", {32'h0, rd_data[63:32]}, 64'hDEADBEEF);
        check("rd0_addr0", {32'h0, rd_data[31:0]}, 64'h0);

        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h1234}; rd_addr = {5'd0, 5'd0}; #1;
        check("zero_reg_bypass", {32'h0, rd_data[31:0]}, 64'h0);
        tick();
        wr_en = 2'b00; #1;
        check("zero_reg_stored", {32'h0, rd_data[31:0]}, 64'h0);

        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11}; rd_addr = {5'd5, 5'd7}; #1;
        check("bypass_hi_port", {32'h0, rd_data[31:0]}, 64'h22);
        check("no_bypass_old", {32'h0, b_rd_data[31:0]}, 64'h0);
        check("bypass_other_port", {32'h0, rd_data[63:32]}, 64'hDEADBEEF);
        tick();
        wr_en = 2'b00; #1;
        check("stored_hi_port", {32'h0, rd_data[31:0]}, 64'h22);
        check("no_bypass_next", {32'h0, b_rd_data[31:0]}, 64'h22);

        rsv_en = 1'b1; rsv_addr = 5'd3; rd_addr = {5'd0, 5'd3}; #1;
        check("pending_not_yet", {63'h0, rd_pending[0]}, 64'h0);
        tick();
        rsv_en = 1'b0; #1;
        check("pending_set", {63'h0, rd_pending[0]}, 64'h1);
        check("pending_set_b", {63'h0, b_rd_pending[0]}, 64'h1);
        wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h33, 32'h0};
        tick();
        wr_en = 2'b00; #1;
        check("pending_cleared", {63'h0, rd_pending[0]}, 64'h0);
        check("write_addr3", {32'h0, rd_data[31:0]}, 64'h33);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h44}; rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        wr_en = 2'b00; rsv_en = 1'b0; #1;
        check("rsv_wins", {63'h0, rd_pending[0]}, 64'h1);
        check("rsv_write_data", {32'h0, rd_data[31:0]}, 64'h44);
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        rsv_en = 1'b0; rd_addr = {5'd0, 5'd0}; #1;
        check("pending0_never", {63'h0, rd_pending[0]}, 64'h0);

        for (int i = 1; i < 32; i++) begin
            wr_en = 2'b01; wr_addr = {5'd0, 5'(i)}; wr_data = {32'h0, 32'(i) * 32'h01010101};
            tick();
        end
        wr_en = 2'b00; rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        rsv_en = 1'b0; rd_addr = {5'd9, 5'd31}; #1;
        check("fill_reg31", {32'h0, rd_data[31:0]}, 64'h1F1F1F1F);
        check("fill_pending9", {63'h0, rd_pending[1]}, 64'h1);

        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_n = 0;
        done_n = 0;
        for (int k = 0; k < 60; k++) begin
            wr_en = 2'b11; wr_addr = {5'd1, 5'd2}; wr_data = {32'hBAD1, 32'hBAD2};
            rsv_en = 1'b1; rsv_addr = 5'd4; rd_addr = {5'd0, 5'd1}; #1;
            if (clr_busy) busy_n++;
            if (clr_done) done_n++;
            if (k == 5) check("no_bypass_in_clear", {32'h0, rd_data[31:0]}, 64'h0);
            if (!clr_busy) break;
            tick();
        end
        wr_en = 2'b00; rsv_en = 1'b0;
        check("clear_busy_cycles", 64'(busy_n), 64'd33);
        check("clear_done_cycles", 64'(done_n), 64'd1);
        for (int r = 0; r < 32; r++) begin
            rd_addr = {5'(r), 5'(r)}; #1;
            check($sformatf("cleared_reg%0d", r), {32'h0, rd_data[31:0]}, 64'h0);
            check($sformatf("cleared_pend%0d", r), {63'h0, rd_pending[1]}, 64'h0);
        end
        tick();

        wr_en = 2'b01; wr_addr = {5'd0, 5'd20}; wr_data = {32'h0, 32'hAB};
        tick();
        wr_en = 2'b00; rsv_en = 1'b1; rsv_addr = 5'd25;
        tick();
        rsv_en = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        rd_addr = {5'd25, 5'd20}; #1;
        check("midclear_reg20", {32'h0, rd_data[31:0]}, 64'hAB);
        check("midclear_pend25", {63'h0, rd_pending[1]}, 64'h1);
        check("midclear_busy", {63'h0, clr_busy}, 64'h1);
        reset = 1'b1; #1;
        check("abort_reg20", {32'h0, rd_data[31:0]}, 64'h0);
        check("abort_pend25", {63'h0, rd_pending[1]}, 64'h0);
        check("abort_busy", {63'h0, clr_busy}, 64'h0);
        check("abort_done", {63'h0, clr_done}, 64'h0);
        tick();
        check("abort_done_held", {63'h0, clr_done}, 64'h0);
        reset = 1'b0;
        tick();
        check("abort_idle_done", {63'h0, clr_done}, 64'h0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        run_clear(1'b0, busy_n, done_n);
        check("restart_busy_cycles", 64'(busy_n), 64'd33);
        check("restart_done_cycles", 64'(done_n), 64'd1);

        c_wr_en = 1'b1; c_wr_addr = 4'd15; c_wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        c_wr_en = 1'b0; c_rd_addr = {4'd15, 4'd15, 4'd15}; #1;
        check("wide_rd0", c_rd_data[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        check("wide_rd1", c_rd_data[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
        check("wide_rd2", c_rd_data[191:128], 64'hFFFF_FFFF_FFFF_FFFF);
        c_clr_req = 1'b1;
        tick();
        c_clr_req = 1'b0;
        run_clear(1'b1, busy_n, done_n);
        check("wide_busy_cycles", 64'(busy_n), 64'd17);
        check("wide_done_cycles", 64'(done_n), 64'd1);
        check("wide_cleared", c_rd_data[63:0], 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised general-purpose register file for the pipelined core. It replaces the fixed 32x32, 2-read/1-write file and adds:
- configurable width, depth and port counts
- write-to-read bypass
- a per-register pending scoreboard for hazard detection
- a sequenced soft-clear engine for context reset without asserting the global reset
Sits between decode (reads, reservations) and writeback (writes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of registers (power of two, >=2); AW = $clog2(NREGS)
NREAD, 2, number of read ports (>=1)
NWRITE, 2, number of write ports (>=1)
BYPASS, 1, 1 = same-cycle write data forwarded to reads
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
rd_addr  input  NREAD*AW  read addresses; port i in slice [i*AW +: AW]
rd_data  output  NREAD*XLEN  read data; port i in slice [i*XLEN +: XLEN]
rd_pending  output  NREAD  1 = register addressed by read port i has an outstanding reservation
wr_en  input  NWRITE  write enables
wr_addr  input  NWRITE*AW  write addresses
wr_data  input  NWRITE*XLEN  write data
rsv_en  input  1  reserve destination register (instruction issued)
rsv_addr  input  AW  register to mark pending
clr_req  input  1  start soft clear (level, sampled in IDLE)
clr_busy  output  1  soft clear in progress
clr_done  output  1  one-cycle pulse after final register cleared

Behaviour:
- Reset (async, immediate): all registers = 0, all pending bits = 0, FSM = IDLE, index counter = 0.
  - Outputs during and after reset: clr_busy = 0, clr_done = 0, rd_pending = 0, rd_data = 0.
- Reads are combinational, zero latency. Per port, in priority order:
  - ZERO_REG=1 and addr==0 -> data 0.
  - Else BYPASS=1, FSM in IDLE, and any wr_en[j] with wr_addr[j]==addr -> wr_data of the highest-index matching port.
  - Else stored value.
- Writes take effect on the rising edge.
  - Multiple write ports to the same address in one cycle: the highest index wins.
  - ZERO_REG=1: writes to address 0 are discarded.
  - Writes are ignored entirely while clr_busy=1.
- Scoreboard:
  - rsv_en sets pending[rsv_addr] at the edge.
  - Any accepted write clears pending[wr_addr] at the edge.
  - Same-cycle reserve and write to the same address: the reserve wins (pending stays 1).
  - rd_pending[i] = pending[rd_addr[i]], combinational, not bypassed.
  - ZERO_REG=1: pending[0] is never set.
  - Reservations are ignored while clr_busy=1.
- Soft-clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 at edge -> CLEAR, index = 0.
  - CLEAR: each cycle register[index] = 0 and pending[index] = 0; index increments.
    - When index == NREGS-1 the register is cleared and the FSM moves to DONE.
    - Exactly NREGS cycles in CLEAR.
  - DONE: one cycle with clr_done=1 -> IDLE. clr_req is not sampled in DONE.
  - clr_busy=1 in CLEAR and DONE; clr_done=1 only in DONE.
  - clr_req while busy is ignored; a request held high after DONE starts a new clear.
  - Reads during CLEAR return the current stored value (already-cleared indices read 0).
  - Reset mid-clear: immediate full clear, FSM -> IDLE, no clr_done pulse.
- Index counter is AW bits wide. Wrap from NREGS-1 to 0 happens only via the DONE transition.

Test Plan:
- Reset, then write port 0 addr 5 = 0xDEADBEEF; next cycle read port 1 addr 5 -> 0xDEADBEEF. Read addr 0 -> 0 after a write of 0x1234 to addr 0.
- Same cycle: wr0 addr 7 = 0x11, wr1 addr 7 = 0x22, read addr 7 -> 0x22 combinationally (bypass). After the edge, stored value = 0x22. Repeat with BYPASS=0 -> old value that cycle, 0x22 next.
- rsv addr 3 -> rd_pending=1 next cycle. Write addr 3 -> pending 0. Reserve and write addr 3 in the same cycle -> pending stays 1, data updated.
- Fill regs 1..31 with nonzero values, pulse clr_req:
  - clr_busy high for exactly 33 cycles (32 CLEAR + 1 DONE), clr_done high for exactly 1.
  - Writes and reservations issued during the clear leave all registers 0 and pending 0 afterwards.
- Start clear, assert reset at index 10 -> all registers 0 immediately, clr_busy=0, no clr_done pulse. A clr_req afterwards restarts the sequence from index 0.
- NREGS=16, NREAD=3, NWRITE=1, XLEN=64: write 0xFFFF_FFFF_FFFF_FFFF to addr 15, read on all three ports -> all match. Clear completes in 16+1 cycles.
